i2s_transmitter: RTL and testbench
==================================

Name: i2s_transmitter

Overview:
Controller-mode I2S serializer. It generates SCK and WS and shifts stereo sample pairs out on SD. It is the transmit counterpart of the spectrometer's I2S capture path, used for loopback and bench stimulus of inputAndProcessing and as a DAC/codec feed. A one-entry holding register with a valid/ready handshake decouples the producer from the frame timing.

Parameters:
CLK_DIV, 4, clk cycles per SCK half-period; ≥1.
WORD_WIDTH, 16, sample width per channel; must be < SLOT_WIDTH.
SLOT_WIDTH, 32, SCK cycles per channel slot; frame = 2*SLOT_WIDTH SCK cycles.

Ports:
clk  in  1  system clock (27 MHz domain).
reset  in  1  synchronous, active-high.
i_sample_l  in  WORD_WIDTH  left sample, two's complement.
i_sample_r  in  WORD_WIDTH  right sample, two's complement.
i_valid  in  1  sample pair present.
o_ready  out  1  holding register empty.
o_underrun  out  1  one-cycle pulse: frame started with no data.
SCK  out  1  serial bit clock.
WS  out  1  word select; 0 = left, 1 = right.
SD  out  1  serial data, MSB first.

Behaviour:
- Reset values: SCK=0, WS=1, SD=0, o_ready=1, o_underrun=0, divider=0, frame bit index b=2*SLOT_WIDTH-1, holding register empty, shift registers zero.
- Reset is synchronous, applies mid-frame, and discards all held and in-flight data.
- Divider counts 0..CLK_DIV-1. At terminal count, SCK toggles and the divider wraps.
- Falling-edge event (FE): the cycle in which registered SCK goes 1→0. The first FE occurs 2*CLK_DIV cycles after reset deasserts.
- On each FE: b increments modulo 2*SLOT_WIDTH, and WS/SD update in the same cycle, so they are stable across the following rising edge.
- WS = 0 for b in 0..SLOT_WIDTH-1 and 1 for b in SLOT_WIDTH..2*SLOT_WIDTH-1.
- SD carries a one-bit I2S delay. Left bits MSB..LSB occupy b=1..WORD_WIDTH; right bits occupy b=SLOT_WIDTH+1..SLOT_WIDTH+WORD_WIDTH. All other positions are 0.
- Frame start is the FE with b→0.
  - Holding register full: load left/right shift registers and clear full.
  - Holding register empty: load zeros and assert o_underrun for exactly that cycle.
- Handshake: transfer occurs when i_valid && o_ready. o_ready = !full, registered.
- A transfer in the same cycle as frame-start consumption is allowed. The old pair is consumed, the new pair is stored, and full stays 1.
- i_sample_* may change freely when no transfer occurs.
- Latency: an accepted pair appears at the next frame start. Its left MSB is on SD at the FE after that frame start.

Optional Feature:
I2S_TX_TEST_PATTERN_EN:
- Defined: adds input i_test_mode (1 bit). When 1, each frame start loads an internal WORD_WIDTH-bit counter value as left and its bitwise inverse as right, ignoring the holding register. The counter increments by 1 per frame and resets to 0. o_underrun is held 0 and handshake behaviour is unchanged.
- Undefined: port and counter are absent; behaviour is as above.

Decomposition:
- Package i2s_pkg: default SLOT_WIDTH/WORD_WIDTH constants, the frame-bit-index width function (clog2 of 2*SLOT_WIDTH), and the WS polarity constants WS_LEFT=0 and WS_RIGHT=1. The existing I2S receiver shares these.
- Sub-module i2s_sck_gen: divider plus SCK register, emitting SCK, a one-cycle FE strobe and a one-cycle rising-edge strobe.

Test Plan:
1. CLK_DIV=2, WORD=16, SLOT=32; reset, then send L=16'hA5C3, R=16'h8001 → bench decoder on SCK rising edges reads left 0xA5C3 and right 0x8001 in frame 1. SCK period is 4 clk and the frame is 256 clk. WS is low for 32 bits then high for 32.
2. No i_valid after reset → first frame SD all zero. o_underrun pulses once per frame start, a 1-cycle pulse every 256 clk.
3. Present pairs 0x0001/0x0002 and 0x0003/0x0004 back-to-back → second is held with o_ready=0 until frame start. Both appear in consecutive frames with no underrun and no loss.
4. Assert i_valid in the exact frame-start cycle with the register full → old pair transmits, new pair transmits in the next frame, and o_ready stays 0 across that cycle.
5. Assert reset at b=10 of the left slot → next cycle SCK=0, WS=1, SD=0, o_ready=1. Timing restarts with the first FE 4 clk later, and pre-reset data never appears.
6. With I2S_TX_TEST_PATTERN_EN and i_test_mode=1 → frames carry L=0x0000/R=0xFFFF, then L=0x0001/R=0xFFFE, and so on. o_underrun stays 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S constants for the transmit and capture paths: default slot/word
// sizes, WS polarity and the frame-bit-index width helper.
package i2s_pkg;

  localparam int SLOT_WIDTH_DEF = 32;
  localparam int WORD_WIDTH_DEF = 16;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  function automatic int bidx_width(input int slot_width);
    return $clog2(2 * slot_width);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Bit-clock generator: divider plus registered SCK, with one-cycle strobes
// marking the cycle in which SCK falls (fe_o) or rises (re_o).
module i2s_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic sck_o,
  output logic fe_o,
  output logic re_o
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          tc;

  assign tc = (div_q == DW'(CLK_DIV - 1));

  always_comb begin
    div_d = tc ? '0 : div_q + 1'b1;
    sck_d = tc ? ~sck_q : sck_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;
  assign fe_o  = tc & sck_q;
  assign re_o  = tc & ~sck_q;

endmodule

// File: rtl/i2s_transmitter.sv
// Controller-mode I2S transmitter with a one-entry holding register.
// Optional I2S_TX_TEST_PATTERN_EN adds i_test_mode: counter/inverse pattern frames.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int WORD_WIDTH = WORD_WIDTH_DEF,
  parameter int SLOT_WIDTH = SLOT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] i_sample_l,
  input  logic [WORD_WIDTH-1:0] i_sample_r,
  input  logic                  i_valid,
`ifdef I2S_TX_TEST_PATTERN_EN
  input  logic                  i_test_mode,
`endif
  output logic                  o_ready,
  output logic                  o_underrun,
  output logic                  SCK,
  output logic                  WS,
  output logic                  SD
);

  localparam int BW = bidx_width(SLOT_WIDTH);
  localparam logic [BW-1:0] B_LAST = BW'(2 * SLOT_WIDTH - 1);

  logic fe, sck_re_unused;

  i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk   (clk),
    .reset (reset),
    .sck_o (SCK),
    .fe_o  (fe),
    .re_o  (sck_re_unused)
  );

  logic [BW-1:0]         b_q, b_d, b_n;
  logic                  ws_q, ws_d, sd_q, sd_d, urun_q, urun_d;
  logic                  full_q, full_d, xfer, consume;
  logic [WORD_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [WORD_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [WORD_WIDTH-1:0] cnt_q, cnt_d;
  logic                  test_mode;

`ifdef I2S_TX_TEST_PATTERN_EN
  assign test_mode = i_test_mode;
`else
  assign test_mode = 1'b0;
`endif

  assign b_n  = (b_q == B_LAST) ? '0 : b_q + 1'b1;
  assign xfer = i_valid & ~full_q;

  always_comb begin
    b_d      = b_q;
    ws_d     = ws_q;
    sd_d     = sd_q;
    urun_d   = 1'b0;
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    cnt_d    = cnt_q;
    consume  = 1'b0;
    if (fe) begin
      b_d  = b_n;
      ws_d = (b_n >= BW'(SLOT_WIDTH)) ? WS_RIGHT : WS_LEFT;
      sd_d = 1'b0;
      if (b_n == '0) begin
        if (test_mode) begin
          sh_l_d = cnt_q;
          sh_r_d = ~cnt_q;
          cnt_d  = cnt_q + 1'b1;
        end else if (full_q) begin
          sh_l_d  = hold_l_q;
          sh_r_d  = hold_r_q;
          consume = 1'b1;
        end else begin
          sh_l_d = '0;
          sh_r_d = '0;
          urun_d = 1'b1;
        end
      end else if (b_n <= BW'(WORD_WIDTH)) begin
        sd_d   = sh_l_q[WORD_WIDTH-1];
        sh_l_d = {sh_l_q[WORD_WIDTH-2:0], 1'b0};
      end else if ((b_n > BW'(SLOT_WIDTH)) && (b_n <= BW'(SLOT_WIDTH + WORD_WIDTH))) begin
        sd_d   = sh_r_q[WORD_WIDTH-1];
        sh_r_d = {sh_r_q[WORD_WIDTH-2:0], 1'b0};
      end
    end
    // a pair may land in the same cycle the previous one is consumed
    full_d   = xfer | (full_q & ~consume);
    hold_l_d = xfer ? i_sample_l : hold_l_q;
    hold_r_d = xfer ? i_sample_r : hold_r_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      b_q      <= B_LAST;
      ws_q     <= WS_RIGHT;
      sd_q     <= 1'b0;
      urun_q   <= 1'b0;
      full_q   <= 1'b0;
      hold_l_q <= '0;
      hold_r_q <= '0;
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      cnt_q    <= '0;
    end else begin
      b_q      <= b_d;
      ws_q     <= ws_d;
      sd_q     <= sd_d;
      urun_q   <= urun_d;
      full_q   <= full_d;
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      cnt_q    <= cnt_d;
    end
  end

  assign WS         = ws_q;
  assign SD         = sd_q;
  assign o_ready    = ~full_q;
  assign o_underrun = urun_q;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Scoreboard bench for i2s_transmitter: an SD/WS decoder on SCK rising edges
// compares each completed frame against queued expected pairs.
module tb_i2s_transmitter;

  localparam int CLK_DIV = 2;
  localparam int W = 16;
  localparam int S = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [W-1:0] sl = '0, sr = '0;
  logic valid = 1'b0;
  logic ready, urun, sck, ws, sd;
`ifdef I2S_TX_TEST_PATTERN_EN
  logic test_mode = 1'b0;
`endif

  i2s_transmitter #(.CLK_DIV(CLK_DIV), .WORD_WIDTH(W), .SLOT_WIDTH(S)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_sample_l (sl),
    .i_sample_r (sr),
    .i_valid    (valid),
`ifdef I2S_TX_TEST_PATTERN_EN
    .i_test_mode(test_mode),
`endif
    .o_ready    (ready),
    .o_underrun (urun),
    .SCK        (sck),
    .WS         (ws),
    .SD         (sd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int t0 = 0;

  typedef struct {
    logic [W-1:0] l;
    logic [W-1:0] r;
    int           u;
  } frame_t;
  frame_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic frame_t mk(input logic [W-1:0] l, input logic [W-1:0] r, input int u);
    frame_t f;
    f.l = l; f.r = r; f.u = u;
    return f;
  endfunction

  // Monitor: decodes frames independently of stimulus.
  initial begin
    logic prev_sck, prev_ws, in_frame, have_fs;
    int bitpos, ws_err, pad_err, urun_cnt, fr_urun, last_fs;
    logic [W-1:0] dl, dr;
    frame_t e;
    prev_sck = 0; prev_ws = 1; in_frame = 0; have_fs = 0;
    bitpos = 0; ws_err = 0; pad_err = 0; urun_cnt = 0; fr_urun = 0; last_fs = 0;
    dl = '0; dr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_sck = 0; prev_ws = 1; in_frame = 0; have_fs = 0; urun_cnt = 0;
      end else begin
        if (urun) urun_cnt++;
        if (sck && !prev_sck) begin
          if (!ws && prev_ws) begin
            if (have_fs) chk("frame_len_clk", cyc - last_fs, 2 * S * 2 * CLK_DIV);
            last_fs = cyc; have_fs = 1;
            in_frame = 1; bitpos = 0; dl = '0; dr = '0; ws_err = 0; pad_err = 0;
            fr_urun = urun_cnt; urun_cnt = 0;
          end
          if (in_frame) begin
            if (ws !== (bitpos >= S)) ws_err++;
            if (bitpos >= 1 && bitpos <= W) dl = {dl[W-2:0], sd};
            else if (bitpos >= S + 1 && bitpos <= S + W) dr = {dr[W-2:0], sd};
            else if (sd !== 1'b0) pad_err++;
            if (bitpos == 2 * S - 1) begin
              if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("frame_left", dl, e.l);
                chk("frame_right", dr, e.r);
                chk("frame_underrun", fr_urun, e.u);
                chk("frame_ws_pattern", ws_err, 0);
                chk("frame_pad_zero", pad_err, 0);
              end
              in_frame = 0;
            end
            bitpos++;
          end
          prev_ws = ws;
        end
        prev_sck = sck;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sck", sck, 0);
    chk("rst_ws", ws, 1);
    chk("rst_sd", sd, 0);
    chk("rst_ready", ready, 1);
    chk("rst_underrun", urun, 0);
    expq.delete();
    reset = 1'b0;
    t0 = cyc;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [W-1:0] l, input logic [W-1:0] r);
    logic rd, ok;
    ok = 0;
    sl = l; sr = r; valid = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk); rd = ready;
      @(posedge clk); #1;
      if (rd) begin ok = 1; break; end
    end
    valid = 1'b0;
    chk("send_accepted", ok, 1);
  endtask

  task automatic wait_urun(output int t);
    t = -1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (urun) begin t = cyc; break; end
    end
    chk("underrun_seen", (t >= 0), 1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 4000 && expq.size() > 0; k++) @(posedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tb, tr1, tr2;
    logic prev;

    // 1: single pair after an underrun frame; SCK period
    do_reset();
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    expq.push_back(mk(16'hA5C3, 16'h8001, 0));
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    wait_cyc(t0 + 5);
    send(16'hA5C3, 16'h8001);
    tr1 = -1; tr2 = -1; prev = sck;
    for (int k = 0; k < 40 && tr2 < 0; k++) begin
      @(negedge clk);
      if (sck && !prev) begin
        if (tr1 < 0) tr1 = cyc; else tr2 = cyc;
      end
      prev = sck;
    end
    chk("sck_period_clk", tr2 - tr1, 2 * CLK_DIV);
    wait_drain();

    // 2: no data -> underrun pulses, one per frame
    do_reset();
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    wait_urun(ta);
    chk("first_fe_latency", ta - t0, 2 * CLK_DIV);
    @(posedge clk); #1;
    chk("underrun_one_cycle", urun, 0);
    wait_urun(tb);
    chk("underrun_interval", tb - ta, 2 * S * 2 * CLK_DIV);
    wait_drain();

    // 3: back-to-back pairs, second held until frame start
    do_reset();
    expq.push_back(mk(16'h0001, 16'h0002, 0));
    expq.push_back(mk(16'h0003, 16'h0004, 0));
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    send(16'h0001, 16'h0002);
    chk("ready_low_when_full", ready, 0);
    send(16'h0003, 16'h0004);
    chk("second_accept_cycle", cyc - t0, 2 * CLK_DIV + 1);
    wait_drain();

    // 4: valid raised exactly in the frame-start cycle with register full
    do_reset();
    expq.push_back(mk(16'h1111, 16'h2222, 0));
    expq.push_back(mk(16'h3333, 16'h4444, 0));
    expq.push_back(mk(16'h5555, 16'h6666, 0));
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    send(16'h1111, 16'h2222);
    wait_cyc(t0 + 8);
    send(16'h3333, 16'h4444);
    wait_cyc(t0 + 2 * CLK_DIV + 2 * S * 2 * CLK_DIV - 1);
    sl = 16'h5555; sr = 16'h6666; valid = 1'b1;
    @(negedge clk);
    chk("ready_low_at_frame_start", ready, 0);
    send(16'h5555, 16'h6666);
    chk("fs_accept_cycle", cyc - t0, 2 * CLK_DIV + 2 * S * 2 * CLK_DIV + 1);
    wait_drain();

    // 5: reset mid left slot discards everything
    do_reset();
    send(16'hDEAD, 16'hBEEF);
    send(16'h1234, 16'h5678);
    wait_cyc(t0 + 2 * CLK_DIV + 9 * 2 * CLK_DIV);
    chk("sd_b9_dead_bit7", sd, 1);
    wait_cyc(t0 + 2 * CLK_DIV + 10 * 2 * CLK_DIV);
    chk("ws_left_b10", ws, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_sck", sck, 0);
    chk("midrst_ws", ws, 1);
    chk("midrst_sd", sd, 0);
    chk("midrst_ready", ready, 1);
    expq.delete();
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    expq.push_back(mk(16'h0000, 16'h0000, 1));
    @(posedge clk); #1;
    reset = 1'b0;
    t0 = cyc;
    wait_urun(ta);
    chk("midrst_first_fe", ta - t0, 2 * CLK_DIV);
    wait_drain();

`ifdef I2S_TX_TEST_PATTERN_EN
    // 6: test pattern frames
    test_mode = 1'b1;
    do_reset();
    expq.push_back(mk(16'h0000, 16'hFFFF, 0));
    expq.push_back(mk(16'h0001, 16'hFFFE, 0));
    expq.push_back(mk(16'h0002, 16'hFFFD, 0));
    wait_drain();
    test_mode = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
